// File: rtl/riscv_mem_pkg.sv
// Shared memory-side types for the program-memory arbiter.
// FSM state, requester id and default bus widths.
package riscv_mem_pkg;

    localparam int PMEM_ADDR_W = 64;
    localparam int PMEM_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

endpackage

// File: rtl/pmem_arb_grant.sv
// Grant selection between IFU and LSU for the shared memory port.
// PMEM_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module pmem_arb_grant
    import riscv_mem_pkg::*;
(
`ifdef PMEM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic fire,
`endif
    input  logic ifu_valid,
    input  logic lsu_valid,
    output logic grant_lsu
);

`ifdef PMEM_ARB_RR_EN
    logic last_lsu_q;
    logic last_lsu_d;

    // Pick a requester; on a tie favour whoever did not win last time
    always_comb begin
        if (ifu_valid && lsu_valid) begin
            grant_lsu = ~last_lsu_q;
        end else if (ifu_valid) begin
            grant_lsu = 1'b0;
        end else begin
            grant_lsu = 1'b1;
        end
    end

    // Remember the winner of every accepted handshake
    always_comb begin
        last_lsu_d = last_lsu_q;
        if (fire) begin
            last_lsu_d = grant_lsu;
        end
    end

    // Last-grant register, LSU after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lsu_q <= 1'b1;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`else
    // Fixed priority: LSU wins any tie, IFU only when alone
    always_comb begin
        if (ifu_valid && !lsu_valid) begin
            grant_lsu = 1'b0;
        end else begin
            grant_lsu = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// Two-requester arbiter in front of a single-outstanding memory port.
// Build option PMEM_ARB_RR_EN enables round-robin tie breaking.
module pmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int DATA_W = PMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_data,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [7:0]        lsu_req_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,

    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    req_id_t           id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic grant_lsu;
    logic is_idle;
    logic fire;
    logic in_resp;

    pmem_arb_grant u_grant (
`ifdef PMEM_ARB_RR_EN
        .clk       (clk),
        .rst       (rst),
        .fire      (fire),
`endif
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .grant_lsu (grant_lsu)
    );

    // Ready only to the granted, valid requester while idle and out of reset
    always_comb begin
        is_idle       = (state_q == ST_IDLE);
        ifu_req_ready = is_idle && !rst && !grant_lsu && ifu_req_valid;
        lsu_req_ready = is_idle && !rst && grant_lsu && lsu_req_valid;
        fire          = ifu_req_ready || lsu_req_ready;
    end

    // Transaction FSM: capture command, wait for ack, return one response
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    state_d = ST_WAIT;
                    if (grant_lsu) begin
                        id_d    = REQ_LSU;
                        addr_d  = lsu_req_addr;
                        wen_d   = lsu_req_wen;
                        wdata_d = lsu_req_wdata;
                        wmask_d = lsu_req_wmask;
                    end else begin
                        id_d    = REQ_IFU;
                        addr_d  = ifu_req_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
                    rdata_d = wen_q ? '0 : mem_rdata;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched command registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= REQ_LSU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory command is the latched request, live only while waiting
    always_comb begin
        mem_req   = (state_q == ST_WAIT);
        mem_addr  = addr_q;
        mem_wen   = wen_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
    end

    // Route the single-cycle response to whoever owns the transaction
    always_comb begin
        in_resp        = (state_q == ST_RESP);
        ifu_resp_valid = in_resp && (id_q == REQ_IFU);
        lsu_resp_valid = in_resp && (id_q == REQ_LSU);
        ifu_resp_data  = ifu_resp_valid ? rdata_q : '0;
        lsu_resp_data  = lsu_resp_valid ? rdata_q : '0;
    end

endmodule
